div_seq: RTL

- Iterative radix-2 divider for the execute stage.
- Handles the divide/modulo operations (signed and unsigned, quotient or remainder) over many cycles instead of in one combinational step.
- Operands arrive from the ID/EX register on the same a/b buses that feed the ALU.
- The execute-stage result mux selects out when done pulses; the hazard unit stalls the pipeline while busy is high.

---
 rtl/div_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for the execute stage.
// Signed/unsigned quotient or remainder in WIDTH+3 cycles; divide-by-zero finishes in one.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             want_rem,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic             r_want_rem;
  logic             r_sign_q;
  logic             r_sign_r;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_div_zero;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Operand magnitudes: negate only negative signed operands
  assign w_mag_a = (r_signed && r_a[WIDTH-1]) ? (~r_a + WIDTH'(1)) : r_a;
  assign w_mag_b = (r_signed && r_b[WIDTH-1]) ? (~r_b + WIDTH'(1)) : r_b;

  // One restoring step: partial remainder stays below the divisor, so the
  // low WIDTH bits of the difference are exact whenever the trial succeeds.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

  assign w_q_fix = (r_signed && r_sign_q) ? (~r_quo + WIDTH'(1)) : r_quo;
  assign w_r_fix = (r_signed && r_sign_r) ? (~r_rem + WIDTH'(1)) : r_rem;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and registered-output decode; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) w_state_nxt = (b == '0) ? S_DONE : S_LOAD;
          else       w_state_nxt = S_IDLE;
        end
        S_LOAD:  w_state_nxt = S_RUN;
        S_RUN:   if (r_cnt == CW'(1)) w_state_nxt = S_FIXUP;
        S_FIXUP: w_state_nxt = S_DONE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
    w_busy_nxt = (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN) ||
                 (w_state_nxt == S_FIXUP);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_signed   <= 1'b0;
      r_want_rem <= 1'b0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      r_cnt      <= '0;
      r_out      <= '0;
      r_div_zero <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a        <= a;
            r_b        <= b;
            r_signed   <= is_signed;
            r_want_rem <= want_rem;
            if (b == '0) begin
              r_quo      <= '1;
              r_rem      <= a;
              r_out      <= want_rem ? a : '1;
              r_div_zero <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_quo    <= w_mag_a;
          r_dvs    <= w_mag_b;
          r_rem    <= '0;
          r_cnt    <= CW'(WIDTH);
          r_sign_q <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
          r_sign_r <= r_a[WIDTH-1];
        end
        S_RUN: begin
          r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIXUP: begin
          r_quo      <= w_q_fix;
          r_rem      <= w_r_fix;
          r_out      <= r_want_rem ? w_r_fix : w_q_fix;
          r_div_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign out      = r_out;
  assign div_zero = r_div_zero;

endmodule
